oled_cmd_decoder: RTL
=====================

# oled_cmd_decoder

Responder-side decoder for the PmodOLED 4-wire SPI command stream (CS, SCLK, SDIN, DC plus RES/VDD/VBAT power controls). It receives bytes MSB-first, separates command from data bytes, decodes the SSD1306 command subset used by the board, and holds the resulting panel configuration in registers. It also flags power-sequencing violations. It sits on the far end of the OLED bus as an on-board loopback checker and simulation model for the initialization and display controllers.

## Interface
Parameters:
- none; all opcodes and defaults come from the shared package.

Ports:
- CLK  in  1  system clock (100 MHz)
- RST  in  1  reset, synchronous, active-high
- CS  in  1  SPI chip select, active-low, asynchronous to CLK
- SCLK  in  1  SPI clock, idle high, data sampled on rising edge, asynchronous
- SDIN  in  1  SPI data, MSB first, asynchronous
- DC  in  1  0 = command byte, 1 = data byte, asynchronous
- RES  in  1  panel reset, active-low, asynchronous
- VDD  in  1  logic supply enable, active-low
- VBAT  in  1  panel supply enable, active-low
- rx_byte  out  8  last complete byte
- rx_valid  out  1  one-cycle strobe: rx_byte/rx_is_data updated
- rx_is_data  out  1  DC value captured with the byte
- disp_on  out  1  0xAE → 0, 0xAF → 1
- contrast  out  8  argument of 0x81
- charge_pump  out  1  bit 2 of the 0x8D argument
- precharge  out  8  argument of 0xD9
- com_cfg  out  8  argument of 0xDA
- seg_remap  out  1  0xA0 → 0, 0xA1 → 1
- com_scan_rev  out  1  0xC0 → 0, 0xC8 → 1
- entire_on  out  1  0xA4 → 0, 0xA5 → 1
- invert  out  1  0xA6 → 0, 0xA7 → 1
- unknown_cmd  out  1  one-cycle strobe: unsupported opcode
- proto_err  out  1  one-cycle strobe: data byte received while an argument was pending
- seq_err  out  1  sticky power-sequence violation

## Operation
- CS, SCLK, SDIN, DC and RES each pass through a 2-FF synchronizer. A SCLK rising edge is detected as sync2 = 1 and previous = 0.
- Byte receiver:
  - On each SCLK rising edge with CS low, shift SDIN into the shift register and increment the 3-bit bit count.
  - The 8th edge completes the byte; DC is captured on that same edge.
  - CS high clears the bit count immediately, so a partial byte is discarded with no strobe.
- Decoder FSM states:
  - CMD: on a command byte, apply a one-byte opcode directly. For 0x81, 0x8D, 0xD9 or 0xDA, latch the opcode and go to ARG. Any other opcode pulses unknown_cmd and stays in CMD.
  - ARG: the next command byte is the argument. Write it to the register selected by the latched opcode, then return to CMD.
  - Data byte in CMD: only rx_valid is strobed.
  - Data byte in ARG: pulse proto_err, return to CMD, leave registers unchanged.
  - CS deassertion does not leave ARG; a pending argument survives across CS frames.
- Panel reset: while synchronized RES = 0, the shift register, bit count and FSM (to CMD) are held, and configuration registers take their defaults.
- Defaults (applied at RST and during RES low): disp_on 0, contrast 0x7F, charge_pump 0, precharge 0x22, com_cfg 0x12, seg_remap 0, com_scan_rev 0, entire_on 0, invert 0.
- seq_err is set, and stays set until RST, if any of these occurs:
  - VBAT = 0 while VDD = 1;
  - 0xAF is accepted while VBAT = 1;
  - a 0x8D argument is written while VBAT = 0.
- RES low does not clear seq_err.

## Timing
- Reset values: rx_byte 0x00, rx_valid 0, rx_is_data 0, unknown_cmd 0, proto_err 0, seq_err 0, configuration outputs at their defaults.
- rx_valid, and any register update or strobe caused by the same byte, occur in the same cycle: 4 CLK cycles after the first CLK edge that samples raw SCLK high on the 8th bit.
- Strobes are exactly 1 cycle wide.
- SCLK high and low phases must each be at least 4 CLK cycles. SDIN and DC must be stable 3 CLK cycles before the SCLK rise. Faster SCLK is outside the specification.
- RST takes priority over every other input. A byte completing in the same cycle that RES sync goes low is discarded.

## Structure
- Shared package oled_pkg holds:
  - opcode constants (0xAE/AF, 0xA0/A1, 0xC0/C8, 0xA4/A5, 0xA6/A7, 0x81, 0x8D, 0xD9, 0xDA);
  - the default values listed above;
  - the FSM state encoding (CMD, ARG).
- One sub-module, spi_byte_rx, contains the synchronizers, edge detect, shift register and bit count, and outputs byte/valid/is_data. The decoder FSM and configuration registers live in the top module.

## Test plan
- Full init stream: AE, 8D 14, D9 F1, 81 0F, A0, C0, DA 00, AF, sent with VDD→0 before the stream and VBAT→0 after D9 F1. Expect disp_on 1, charge_pump 1, precharge 0xF1, contrast 0x0F, com_cfg 0x00, seq_err 0, unknown_cmd never pulsed.
- 0x81 in one CS frame, then 0x33 in the next frame → contrast 0x33. Also: 5 bits, then CS high, then byte 0xA5 → only one rx_valid, entire_on 1.
- 0xD9 followed by a data byte 0x55 (DC = 1) → proto_err pulse, precharge stays 0x22. A following 0xA7 sets invert 1.
- 0xE3 → unknown_cmd pulse, all registers unchanged. Then RES low for 100 cycles → all defaults, even after a prior 0x81 0x00.
- Sequence errors, each run from RST: AF with VBAT = 1; VBAT = 0 while VDD = 1; 8D 10 with VBAT = 0. Each → seq_err 1, which stays 1 through RES low and clears only on RST.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared opcodes, power-on defaults and decoder state encoding for the OLED command decoder.
package oled_pkg;

    localparam logic [7:0] OP_DISP_OFF  = 8'hAE;
    localparam logic [7:0] OP_DISP_ON   = 8'hAF;
    localparam logic [7:0] OP_SEG_NORM  = 8'hA0;
    localparam logic [7:0] OP_SEG_REMAP = 8'hA1;
    localparam logic [7:0] OP_COM_NORM  = 8'hC0;
    localparam logic [7:0] OP_COM_REV   = 8'hC8;
    localparam logic [7:0] OP_ENT_OFF   = 8'hA4;
    localparam logic [7:0] OP_ENT_ON    = 8'hA5;
    localparam logic [7:0] OP_INV_OFF   = 8'hA6;
    localparam logic [7:0] OP_INV_ON    = 8'hA7;
    localparam logic [7:0] OP_CONTRAST  = 8'h81;
    localparam logic [7:0] OP_CHG_PUMP  = 8'h8D;
    localparam logic [7:0] OP_PRECHARGE = 8'hD9;
    localparam logic [7:0] OP_COM_CFG   = 8'hDA;

    typedef struct packed {
        logic       disp_on;
        logic [7:0] contrast;
        logic       charge_pump;
        logic [7:0] precharge;
        logic [7:0] com_cfg;
        logic       seg_remap;
        logic       com_scan_rev;
        logic       entire_on;
        logic       invert;
    } cfg_t;

    localparam cfg_t CFG_DEFAULT = '{
        disp_on:      1'b0,
        contrast:     8'h7F,
        charge_pump:  1'b0,
        precharge:    8'h22,
        com_cfg:      8'h12,
        seg_remap:    1'b0,
        com_scan_rev: 1'b0,
        entire_on:    1'b0,
        invert:       1'b0
    };

    typedef enum logic {ST_CMD, ST_ARG} dec_state_t;

endpackage

// File: rtl/oled_cmd_decoder_if.sv
// PmodOLED bus pins: SPI byte lane plus panel reset and supply enables.
interface oled_cmd_decoder_if;
    logic CS;
    logic SCLK;
    logic SDIN;
    logic DC;
    logic RES;
    logic VDD;
    logic VBAT;

    modport master (output CS, SCLK, SDIN, DC, RES, VDD, VBAT);
    modport slave  (input  CS, SCLK, SDIN, DC, RES, VDD, VBAT);
endinterface

// File: rtl/oled_cmd_decoder_spi_byte_rx.sv
// Synchronizes the SPI pins and assembles MSB-first bytes; byte_vld is a one-cycle
// strobe 3 CLK edges after the first edge that samples the 8th SCLK rise.
module spi_byte_rx (
    input  logic       CLK,
    input  logic       RST,
    input  logic       cs,
    input  logic       sclk,
    input  logic       sdin,
    input  logic       dc,
    input  logic       res,
    output logic [7:0] byte_dat,
    output logic       byte_vld,
    output logic       byte_is_data,
    output logic       res_sync
);
    // index 0 is the first flop, index 1 the synchronized value
    logic [1:0] cs_s, sclk_s, sdin_s, dc_s, res_s;
    logic       sclk_prev;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       done_q, done_dc_q;
    logic       rise;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cs_s      <= 2'b11;
            sclk_s    <= 2'b11;
            sdin_s    <= 2'b00;
            dc_s      <= 2'b00;
            res_s     <= 2'b11;
            sclk_prev <= 1'b1;
        end else begin
            cs_s      <= {cs_s[0], cs};
            sclk_s    <= {sclk_s[0], sclk};
            sdin_s    <= {sdin_s[0], sdin};
            dc_s      <= {dc_s[0], dc};
            res_s     <= {res_s[0], res};
            sclk_prev <= sclk_s[1];
        end
    end

    assign rise     = sclk_s[1] & ~sclk_prev;
    assign res_sync = res_s[1];

    always_ff @(posedge CLK) begin
        if (RST || !res_s[1]) begin
            shreg        <= 8'h00;
            bit_cnt      <= 3'd0;
            done_q       <= 1'b0;
            done_dc_q    <= 1'b0;
            byte_vld     <= 1'b0;
            byte_dat     <= 8'h00;
            byte_is_data <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cs_s[1]) begin
                bit_cnt <= 3'd0;
            end else if (rise) begin
                shreg   <= {shreg[6:0], sdin_s[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    done_q    <= 1'b1;
                    done_dc_q <= dc_s[1];
                end
            end
            byte_vld <= done_q;
            if (done_q) begin
                byte_dat     <= shreg;
                byte_is_data <= done_dc_q;
            end
        end
    end
endmodule

// File: rtl/oled_cmd_decoder.sv
// SSD1306 command-subset decoder holding the panel configuration; all outputs
// update 4 CLK edges after the 8th SCLK rise is first sampled. Flags power-sequence violations.
module oled_cmd_decoder
    import oled_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    oled_cmd_decoder_if.slave    bus,
    output logic [7:0]           rx_byte,
    output logic                 rx_valid,
    output logic                 rx_is_data,
    output logic                 disp_on,
    output logic [7:0]           contrast,
    output logic                 charge_pump,
    output logic [7:0]           precharge,
    output logic [7:0]           com_cfg,
    output logic                 seg_remap,
    output logic                 com_scan_rev,
    output logic                 entire_on,
    output logic                 invert,
    output logic                 unknown_cmd,
    output logic                 proto_err,
    output logic                 seq_err
);
    logic [7:0] byte_dat;
    logic       byte_vld, byte_is_data, res_sync, byte_take;
    dec_state_t state, state_nxt;
    logic [7:0] op_q, op_nxt;
    cfg_t       cfg, cfg_nxt;
    logic       unknown_nxt, proto_nxt, seq_hit;

    spi_byte_rx u_rx (
        .CLK          (CLK),
        .RST          (RST),
        .cs           (bus.CS),
        .sclk         (bus.SCLK),
        .sdin         (bus.SDIN),
        .dc           (bus.DC),
        .res          (bus.RES),
        .byte_dat     (byte_dat),
        .byte_vld     (byte_vld),
        .byte_is_data (byte_is_data),
        .res_sync     (res_sync)
    );

    // a byte landing as panel reset asserts is dropped
    assign byte_take = byte_vld & res_sync;

    always_ff @(posedge CLK) begin
        if (RST || !res_sync) state <= ST_CMD;
        else                  state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        op_nxt      = op_q;
        cfg_nxt     = cfg;
        unknown_nxt = 1'b0;
        proto_nxt   = 1'b0;
        seq_hit     = ~bus.VBAT & bus.VDD;
        if (byte_take) begin
            if (state == ST_ARG) begin
                state_nxt = ST_CMD;
                if (byte_is_data) begin
                    proto_nxt = 1'b1;
                end else begin
                    case (op_q)
                        OP_CONTRAST:  cfg_nxt.contrast  = byte_dat;
                        OP_PRECHARGE: cfg_nxt.precharge = byte_dat;
                        OP_COM_CFG:   cfg_nxt.com_cfg   = byte_dat;
                        OP_CHG_PUMP: begin
                            cfg_nxt.charge_pump = byte_dat[2];
                            if (!bus.VBAT) seq_hit = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else if (!byte_is_data) begin
                case (byte_dat)
                    OP_DISP_OFF:  cfg_nxt.disp_on      = 1'b0;
                    OP_DISP_ON: begin
                        cfg_nxt.disp_on = 1'b1;
                        if (bus.VBAT) seq_hit = 1'b1;
                    end
                    OP_SEG_NORM:  cfg_nxt.seg_remap    = 1'b0;
                    OP_SEG_REMAP: cfg_nxt.seg_remap    = 1'b1;
                    OP_COM_NORM:  cfg_nxt.com_scan_rev = 1'b0;
                    OP_COM_REV:   cfg_nxt.com_scan_rev = 1'b1;
                    OP_ENT_OFF:   cfg_nxt.entire_on    = 1'b0;
                    OP_ENT_ON:    cfg_nxt.entire_on    = 1'b1;
                    OP_INV_OFF:   cfg_nxt.invert       = 1'b0;
                    OP_INV_ON:    cfg_nxt.invert       = 1'b1;
                    OP_CONTRAST, OP_CHG_PUMP, OP_PRECHARGE, OP_COM_CFG: begin
                        op_nxt    = byte_dat;
                        state_nxt = ST_ARG;
                    end
                    default: unknown_nxt = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q        <= 8'h00;
            cfg         <= CFG_DEFAULT;
            rx_byte     <= 8'h00;
            rx_valid    <= 1'b0;
            rx_is_data  <= 1'b0;
            unknown_cmd <= 1'b0;
            proto_err   <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            rx_valid    <= byte_take;
            unknown_cmd <= unknown_nxt;
            proto_err   <= proto_nxt;
            if (byte_take) begin
                rx_byte    <= byte_dat;
                rx_is_data <= byte_is_data;
            end
            if (seq_hit) seq_err <= 1'b1;
            if (!res_sync) begin
                cfg <= CFG_DEFAULT;
            end else begin
                cfg  <= cfg_nxt;
                op_q <= op_nxt;
            end
        end
    end

    assign disp_on      = cfg.disp_on;
    assign contrast     = cfg.contrast;
    assign charge_pump  = cfg.charge_pump;
    assign precharge    = cfg.precharge;
    assign com_cfg      = cfg.com_cfg;
    assign seg_remap    = cfg.seg_remap;
    assign com_scan_rev = cfg.com_scan_rev;
    assign entire_on    = cfg.entire_on;
    assign invert       = cfg.invert;
endmodule
